// File: rtl/ch1_sweep_if.sv
// Channel 1 sweep bus: NR10/NR13/NR14 fields in,
// frequency bus, load strobe and status out.
interface ch1_sweep_if #(
  parameter int FREQ_W = 11
);
  logic              sweep_tick;
  logic              ch1_restart;
  logic [2:0]        nr10_period;
  logic              nr10_negate;
  logic [2:0]        nr10_shift;
  logic [FREQ_W-1:0] nr1x_freq;
  logic [FREQ_W-1:0] acc_d;
  logic              freq_load;
  logic              ch1_sweep_off;
  logic              sweep_busy;

  modport master (
    output sweep_tick,
    output ch1_restart,
    output nr10_period,
    output nr10_negate,
    output nr10_shift,
    output nr1x_freq,
    input  acc_d,
    input  freq_load,
    input  ch1_sweep_off,
    input  sweep_busy
  );

  modport slave (
    input  sweep_tick,
    input  ch1_restart,
    input  nr10_period,
    input  nr10_negate,
    input  nr10_shift,
    input  nr1x_freq,
    output acc_d,
    output freq_load,
    output ch1_sweep_off,
    output sweep_busy
  );
endinterface

// File: rtl/ch1_sweep.sv
// Channel 1 frequency-sweep engine: shadow frequency,
// sweep timer, overflow check and sweep disable.
module ch1_sweep #(
  parameter int FREQ_W             = 11,
  parameter int ZERO_PERIOD_RELOAD = 8
) (
  input logic         dyfa_1mhz,
  input logic         napu_reset,
  ch1_sweep_if.slave  sw
);

  localparam int TMR_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHK   = 3'd1,
    CALC1 = 3'd2,
    WRITE = 3'd3,
    CALC2 = 3'd4
  } state_t;

  state_t            state;
  logic [FREQ_W-1:0] shadow;
  logic [FREQ_W-1:0] result;
  logic [TMR_W-1:0]  timer;
  logic              sweep_en;
  logic              neg_used;
  logic [FREQ_W-1:0] acc_d;
  logic              freq_load;
  logic              sweep_off;

  logic [FREQ_W-1:0] delta;
  logic [FREQ_W:0]   sum;
  logic              ovf;
  logic              per_zero;
  logic              shift_nz;
  logic [TMR_W-1:0]  reload;
  logic              do_calc;

  // Sweep arithmetic on the current shadow; subtract never overflows
  always_comb begin
    delta = shadow >> sw.nr10_shift;
    if (sw.nr10_negate)
      sum = {1'b0, shadow} - {1'b0, delta};
    else
      sum = {1'b0, shadow} + {1'b0, delta};
    ovf      = !sw.nr10_negate && sum[FREQ_W];
    per_zero = (sw.nr10_period == 3'd0);
    shift_nz = (sw.nr10_shift != 3'd0);
    reload   = per_zero ? TMR_W'(ZERO_PERIOD_RELOAD)
                        : {1'b0, sw.nr10_period};
    do_calc  = (state == CHK) || (state == CALC1) ||
               (state == CALC2);
  end

  // Sweep FSM; a restart overrides anything in flight
  always_ff @(posedge dyfa_1mhz or negedge napu_reset) begin
    if (!napu_reset) begin
      state     <= IDLE;
      shadow    <= '0;
      result    <= '0;
      timer     <= '0;
      sweep_en  <= 1'b0;
      neg_used  <= 1'b0;
      acc_d     <= '0;
      freq_load <= 1'b0;
      sweep_off <= 1'b0;
    end else begin
      freq_load <= 1'b0;
      if (neg_used && !sw.nr10_negate)
        sweep_off <= 1'b1;
      if (sw.ch1_restart) begin
        shadow    <= sw.nr1x_freq;
        acc_d     <= sw.nr1x_freq;
        freq_load <= 1'b1;
        timer     <= reload;
        sweep_en  <= !per_zero || shift_nz;
        neg_used  <= 1'b0;
        sweep_off <= 1'b0;
        state     <= shift_nz ? CHK : IDLE;
      end else begin
        if (do_calc && sw.nr10_negate)
          neg_used <= 1'b1;
        unique case (state)
          IDLE: begin
            if (sw.sweep_tick) begin
              if (timer > 4'd1) begin
                timer <= timer - 4'd1;
              end else begin
                timer <= reload;
                if (sweep_en && !per_zero && !sweep_off)
                  state <= CALC1;
              end
            end
          end
          CHK: begin
            if (ovf)
              sweep_off <= 1'b1;
            state <= IDLE;
          end
          CALC1: begin
            if (ovf) begin
              sweep_off <= 1'b1;
              state     <= IDLE;
            end else if (shift_nz) begin
              result <= sum[FREQ_W-1:0];
              state  <= WRITE;
            end else begin
              state <= IDLE;
            end
          end
          WRITE: begin
            if (!sweep_off) begin
              shadow    <= result;
              acc_d     <= result;
              freq_load <= 1'b1;
            end
            state <= CALC2;
          end
          CALC2: begin
            if (ovf)
              sweep_off <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign sw.acc_d         = acc_d;
  assign sw.freq_load     = freq_load;
  assign sw.ch1_sweep_off = sweep_off;
  assign sw.sweep_busy    = (state != IDLE);

endmodule

// File: tb/tb_ch1_sweep.sv
// Directed bench for the channel 1 sweep engine.
// Expected values are hand-computed sweep results.
module tb_ch1_sweep;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   loads = 0;
  int   ld0;

  ch1_sweep_if #(.FREQ_W(11)) bus ();

  ch1_sweep dut (
    .dyfa_1mhz  (clk),
    .napu_reset (rst_n),
    .sw         (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (bus.freq_load === 1'b1) loads++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setf(input logic [10:0] f,
                      input logic [2:0]  p,
                      input logic        n,
                      input logic [2:0]  s);
    bus.nr1x_freq   = f;
    bus.nr10_period = p;
    bus.nr10_negate = n;
    bus.nr10_shift  = s;
  endtask

  task automatic trig(input logic [10:0] f,
                      input logic [2:0]  p,
                      input logic        n,
                      input logic [2:0]  s);
    setf(f, p, n, s);
    bus.ch1_restart = 1'b1;
    cyc();
    bus.ch1_restart = 1'b0;
  endtask

  task automatic tick();
    bus.sweep_tick = 1'b1;
    cyc();
    bus.sweep_tick = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.sweep_tick  = 1'b0;
    bus.ch1_restart = 1'b0;
    setf(11'h0, 3'd0, 1'b0, 3'd0);
    cyc();
    cyc();
    chk("rst_acc", bus.acc_d, 0);
    chk("rst_load", bus.freq_load, 0);
    chk("rst_off", bus.ch1_sweep_off, 0);
    chk("rst_busy", bus.sweep_busy, 0);
    rst_n = 1'b1;
    cyc();

    // 0x400 up by >>1: 0x600 ok, then 0x900 overflows
    trig(11'h400, 3'd1, 1'b0, 3'd1);
    chk("a_trg_acc", bus.acc_d, 'h400);
    chk("a_trg_load", bus.freq_load, 1);
    chk("a_trg_busy", bus.sweep_busy, 1);
    cyc();
    chk("a_chk_off", bus.ch1_sweep_off, 0);
    chk("a_chk_busy", bus.sweep_busy, 0);
    tick();
    chk("a_c1_busy", bus.sweep_busy, 1);
    chk("a_c1_load", bus.freq_load, 0);
    cyc();
    chk("a_wr_load", bus.freq_load, 0);
    cyc();
    chk("a_wr_acc", bus.acc_d, 'h600);
    chk("a_wr_pulse", bus.freq_load, 1);
    chk("a_wr_off", bus.ch1_sweep_off, 0);
    cyc();
    chk("a_c2_off", bus.ch1_sweep_off, 1);
    chk("a_c2_load", bus.freq_load, 0);
    ld0 = loads;
    tick();
    repeat (4) cyc();
    chk("a_off_noload", loads, ld0);
    chk("a_off_acc", bus.acc_d, 'h600);

    // Trigger check overflow: 0x7F0 + 0x3F8 = 0xBE8
    trig(11'h7F0, 3'd1, 1'b0, 3'd1);
    chk("b_trg_off", bus.ch1_sweep_off, 0);
    chk("b_trg_acc", bus.acc_d, 'h7F0);
    cyc();
    chk("b_chk_off", bus.ch1_sweep_off, 1);
    chk("b_chk_acc", bus.acc_d, 'h7F0);

    // Period 3 subtract: third tick gives 0x100 - 0x40
    trig(11'h100, 3'd3, 1'b1, 3'd2);
    cyc();
    chk("c_trg_off", bus.ch1_sweep_off, 0);
    ld0 = loads;
    tick();
    repeat (3) cyc();
    tick();
    repeat (3) cyc();
    chk("c_2tick_load", loads, ld0);
    chk("c_2tick_acc", bus.acc_d, 'h100);
    tick();
    cyc();
    cyc();
    chk("c_3tick_load", bus.freq_load, 1);
    chk("c_3tick_acc", bus.acc_d, 'h0C0);
    cyc();
    chk("c_c2_off", bus.ch1_sweep_off, 0);
    bus.nr10_negate = 1'b0;
    cyc();
    chk("c_quirk_off", bus.ch1_sweep_off, 1);

    // Sweep disabled: timer free-runs through 8
    trig(11'h0, 3'd0, 1'b0, 3'd0);
    cyc();
    ld0 = loads;
    for (int i = 0; i < 20; i++) begin
      tick();
      cyc();
    end
    chk("d_noload", loads, ld0);
    chk("d_timer", dut.timer, 4);
    chk("d_busy", bus.sweep_busy, 0);

    // Trigger and tick on the same edge
    trig(11'h200, 3'd1, 1'b0, 3'd1);
    cyc();
    setf(11'h300, 3'd2, 1'b0, 3'd1);
    bus.sweep_tick  = 1'b1;
    bus.ch1_restart = 1'b1;
    cyc();
    bus.sweep_tick  = 1'b0;
    bus.ch1_restart = 1'b0;
    chk("e_same_acc", bus.acc_d, 'h300);
    chk("e_same_load", bus.freq_load, 1);
    chk("e_same_timer", dut.timer, 2);
    cyc();
    chk("e_same_busy", bus.sweep_busy, 0);
    ld0 = loads;
    tick();
    chk("e_dec_busy", bus.sweep_busy, 0);
    repeat (3) cyc();
    chk("e_dec_noload", loads, ld0);

    // Trigger lands while CALC1 is in flight
    tick();
    chk("e_c1_busy", bus.sweep_busy, 1);
    trig(11'h150, 3'd1, 1'b0, 3'd0);
    chk("e_abort_acc", bus.acc_d, 'h150);
    chk("e_abort_load", bus.freq_load, 1);
    chk("e_abort_busy", bus.sweep_busy, 0);
    cyc();
    ld0 = loads;
    repeat (3) cyc();
    chk("e_nostale", loads, ld0);
    chk("e_nostale_acc", bus.acc_d, 'h150);

    // Asynchronous reset while in WRITE
    trig(11'h100, 3'd1, 1'b0, 3'd1);
    cyc();
    tick();
    cyc();
    chk("f_wr_busy", bus.sweep_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("f_rst_acc", bus.acc_d, 0);
    chk("f_rst_load", bus.freq_load, 0);
    chk("f_rst_off", bus.ch1_sweep_off, 0);
    chk("f_rst_busy", bus.sweep_busy, 0);
    cyc();
    chk("f_rst_hold", bus.freq_load, 0);
    rst_n = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ch1_sweep.md
Name: ch1_sweep

Overview:
Channel 1 frequency-sweep engine. It consumes the NR10 sweep fields and the NR13/NR14 frequency latches held by the channel 1 register block. It drives the 11-bit frequency bus (acc_d) and its load strobe into the channel 1 frequency counter. It owns the shadow frequency, the sweep timer, the overflow check and the channel-disable decision.

Parameters:
FREQ_W, 11, frequency/shadow width; the overflow limit is 2^FREQ_W-1 (2047).
ZERO_PERIOD_RELOAD, 8, timer reload value used when the NR10 period is 0.

Ports:
dyfa_1mhz  in  1  APU clock; all state updates on its rising edge.
napu_reset  in  1  reset, asynchronous, active-low; clears all state.
sweep_tick  in  1  one-cycle 128 Hz frame-sequencer enable.
ch1_restart  in  1  one-cycle trigger pulse (NR14 bit 7 write).
nr10_period  in  3  sweep period, NR10[6:4], true polarity.
nr10_negate  in  1  NR10[3]; 1 = subtract.
nr10_shift  in  3  NR10[2:0].
nr1x_freq  in  FREQ_W  current NR14[2:0]:NR13 frequency latches.
acc_d  out  FREQ_W  frequency presented to the channel 1 counter.
freq_load  out  1  one-cycle strobe; the counter reloads from acc_d.
ch1_sweep_off  out  1  level; channel disabled by sweep, held until the next restart.
sweep_busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (napu_reset=0, async):
  - shadow=0, timer=0, sweep_en=0, neg_used=0.
  - acc_d=0, freq_load=0, ch1_sweep_off=0.
  - state=IDLE, sweep_busy=0.
  - Reset asserted mid-calculation aborts it; no freq_load is issued.
- Calc (combinational from shadow): delta = shadow >> nr10_shift; sum = shadow ± delta in FREQ_W+1 bits; overflow = sum > 2047 (add only). Subtract never overflows. Any calc with negate=1 sets neg_used.
- States: IDLE, CHK (trigger check), CALC1, WRITE, CALC2.
- Trigger (ch1_restart=1 in any state) has the highest priority. In that cycle:
  - shadow = nr1x_freq; acc_d = nr1x_freq; freq_load = 1.
  - timer = nr10_period, or ZERO_PERIOD_RELOAD if the period is 0.
  - sweep_en = (period != 0) || (shift != 0); neg_used = 0; ch1_sweep_off = 0.
  - Next state is CHK if shift != 0, else IDLE.
  - Any in-flight calculation is discarded.
- CHK (1 cycle): evaluate calc. Overflow -> ch1_sweep_off = 1. Shadow and acc_d are never written. Next state IDLE.
- sweep_tick in IDLE:
  - If timer > 1: timer decrements; stay in IDLE.
  - If timer reaches 0 or was 1: timer reloads (period, or 8 if 0). If sweep_en && period != 0, next state is CALC1; else stay in IDLE.
- sweep_tick outside IDLE is ignored, with no timer change. Ticks are at least 7800 cycles apart, so this cannot occur in normal operation.
- CALC1 (1 cycle): evaluate calc.
  - Overflow -> ch1_sweep_off = 1, next state IDLE.
  - Else if shift != 0 -> latch sum into a result register, next state WRITE.
  - Else -> IDLE.
- WRITE (1 cycle): shadow = result; acc_d = result; freq_load = 1; next state CALC2.
- CALC2 (1 cycle): re-evaluate calc on the new shadow. Overflow -> ch1_sweep_off = 1. No write. Next state IDLE.
- Negate quirk: when neg_used = 1 and nr10_negate = 0, ch1_sweep_off = 1 the next cycle. Evaluated every cycle, cleared only by trigger.
- Latency: trigger to freq_load is 0 cycles (same edge); tick to freq_load is 2 cycles (CALC1, WRITE).
- freq_load is never high for 2 consecutive cycles except on trigger-during-WRITE, where the trigger value wins.
- Once ch1_sweep_off = 1, further ticks still run the timer but never issue freq_load.
- sweep_busy = (state != IDLE).

Test Plan:
- Reset mid-WRITE: pull napu_reset low while in WRITE -> acc_d = 0, freq_load = 0, ch1_sweep_off = 0, state IDLE immediately, without waiting for a clock edge.
- Trigger with freq = 0x400, period = 1, shift = 1, negate = 0 -> acc_d = 0x400 with freq_load pulse; CHK finds 0x600, so ch1_sweep_off stays 0.
  - First tick -> freq_load with acc_d = 0x600 two cycles later; CALC2 finds 0x900 > 2047, so ch1_sweep_off = 1.
- Trigger with freq = 0x7F0, shift = 1 -> CHK overflow (0xBE8) -> ch1_sweep_off = 1 one cycle after trigger; acc_d stays 0x7F0.
- Period = 3, shift = 2, negate = 1, freq = 0x100 -> 2 ticks give no calc.
  - 3rd tick -> acc_d = 0x0C0.
  - Then clear negate -> ch1_sweep_off = 1 next cycle.
- Period = 0, shift = 0 -> sweep_en = 0; 20 ticks produce no freq_load; timer cycles through 8.
- Trigger on the same edge as sweep_tick, and trigger during CALC1 -> the trigger values load, the tick is ignored, the calculation is aborted, and no stale write occurs.
